// File: rtl/lsu_mem_stage.sv
// Load/store memory stage for an RV32I core.
// Takes one decoded LOAD/STORE at a time and checks it for misalignment or an
// illegal width code. Legal accesses go out on a word-wide req/gnt/rvalid port,
// and the stage then reports a load result, a store completion or an error.
// Every output comes straight from a register, so the pulses and the memory
// request change on the same clock edges as the state.

module lsu_mem_stage #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    input  logic [RD_W-1:0] req_rd_i,
    output logic            mem_req_o,
    input  logic            mem_gnt_i,
    output logic [XLEN-1:0] mem_addr_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            wb_valid_o,
    output logic [RD_W-1:0] wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            st_done_o,
    output logic            err_o,
    output logic [XLEN-1:0] err_addr_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [2:0] F3_BYTE  = 3'b000;
    localparam logic [2:0] F3_HALF  = 3'b001;
    localparam logic [2:0] F3_WORD  = 3'b010;
    localparam logic [2:0] F3_BYTEU = 3'b100;
    localparam logic [2:0] F3_HALFU = 3'b101;

    logic [1:0]      state_reg;
    logic [2:0]      funct3_reg;
    logic [1:0]      offset_reg;
    logic [RD_W-1:0] rd_reg;

    logic            req_ready_reg;
    logic            mem_req_reg;
    logic [XLEN-1:0] mem_addr_reg;
    logic            mem_we_reg;
    logic [3:0]      mem_be_reg;
    logic [XLEN-1:0] mem_wdata_reg;
    logic            wb_valid_reg;
    logic [RD_W-1:0] wb_rd_reg;
    logic [XLEN-1:0] wb_data_reg;
    logic            st_done_reg;
    logic            err_reg;
    logic [XLEN-1:0] err_addr_reg;

    logic            req_illegal;
    logic [3:0]      req_be;
    logic [XLEN-1:0] req_lanes;
    logic [7:0]      load_byte;
    logic [15:0]     load_half;
    logic [XLEN-1:0] load_data;

    assign req_ready_o = req_ready_reg;
    assign mem_req_o   = mem_req_reg;
    assign mem_addr_o  = mem_addr_reg;
    assign mem_we_o    = mem_we_reg;
    assign mem_be_o    = mem_be_reg;
    assign mem_wdata_o = mem_wdata_reg;
    assign wb_valid_o  = wb_valid_reg;
    assign wb_rd_o     = wb_rd_reg;
    assign wb_data_o   = wb_data_reg;
    assign st_done_o   = st_done_reg;
    assign err_o       = err_reg;
    assign err_addr_o  = err_addr_reg;

    // Classify the incoming request: alignment and width-code legality, plus byte enables.
    always_comb begin
        req_illegal = 1'b0;
        case (req_funct3_i)
            F3_BYTE, F3_BYTEU: req_illegal = 1'b0;
            F3_HALF, F3_HALFU: req_illegal = req_addr_i[0];
            F3_WORD:           req_illegal = (req_addr_i[1:0] != 2'b00);
            default:           req_illegal = 1'b1;
        endcase
        // Stores have no unsigned variants.
        if (req_we_i && req_funct3_i[2]) begin
            req_illegal = 1'b1;
        end

        case (req_funct3_i[1:0])
            2'b00:   req_be = 4'b0001 << req_addr_i[1:0];
            2'b01:   req_be = 4'b0011 << req_addr_i[1:0];
            default: req_be = 4'b1111;
        endcase
    end

    // Replicate the store data into every byte lane so the enabled lanes carry it.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_store_lane
            assign req_lanes[gi*8 +: 8] =
                (req_funct3_i[1:0] == 2'b00) ? req_wdata_i[7:0] :
                (req_funct3_i[1:0] == 2'b01) ? req_wdata_i[(gi%2)*8 +: 8] :
                                               req_wdata_i[gi*8 +: 8];
        end
    endgenerate

    // Select the addressed byte or half of the read word, then sign- or zero-extend it.
    always_comb begin
        load_byte = mem_rdata_i[{offset_reg, 3'b000} +: 8];
        load_half = mem_rdata_i[{offset_reg[1], 4'b0000} +: 16];
        case (funct3_reg)
            F3_BYTE:  load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
            F3_BYTEU: load_data = {{(XLEN-8){1'b0}}, load_byte};
            F3_HALF:  load_data = {{(XLEN-16){load_half[15]}}, load_half};
            F3_HALFU: load_data = {{(XLEN-16){1'b0}}, load_half};
            default:  load_data = mem_rdata_i;
        endcase
    end

    // Control FSM and all registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= ST_IDLE;
            funct3_reg    <= 3'b000;
            offset_reg    <= 2'b00;
            rd_reg        <= '0;
            req_ready_reg <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_addr_reg  <= '0;
            mem_we_reg    <= 1'b0;
            mem_be_reg    <= 4'b0000;
            mem_wdata_reg <= '0;
            wb_valid_reg  <= 1'b0;
            wb_rd_reg     <= '0;
            wb_data_reg   <= '0;
            st_done_reg   <= 1'b0;
            err_reg       <= 1'b0;
            err_addr_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    req_ready_reg <= 1'b1;
                    // Ready is low for one cycle after reset, so no request is taken then.
                    if (req_ready_reg && req_valid_i) begin
                        req_ready_reg <= 1'b0;
                        funct3_reg    <= req_funct3_i;
                        offset_reg    <= req_addr_i[1:0];
                        rd_reg        <= req_rd_i;
                        if (req_illegal) begin
                            err_reg      <= 1'b1;
                            err_addr_reg <= req_addr_i;
                            state_reg    <= ST_RESP;
                        end else begin
                            mem_req_reg   <= 1'b1;
                            mem_addr_reg  <= {req_addr_i[XLEN-1:2], 2'b00};
                            mem_we_reg    <= req_we_i;
                            mem_be_reg    <= req_be;
                            mem_wdata_reg <= req_lanes;
                            state_reg     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // The memory outputs stay put until the grant. rvalid here is ignored.
                    if (mem_gnt_i) begin
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        mem_be_reg  <= 4'b0000;
                        if (mem_we_reg) begin
                            st_done_reg <= 1'b1;
                            state_reg   <= ST_RESP;
                        end else begin
                            state_reg   <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid_i) begin
                        wb_valid_reg <= 1'b1;
                        wb_data_reg  <= load_data;
                        wb_rd_reg    <= rd_reg;
                        state_reg    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // The result pulse was raised on entry. Drop it and reopen the stage.
                    wb_valid_reg  <= 1'b0;
                    st_done_reg   <= 1'b0;
                    err_reg       <= 1'b0;
                    req_ready_reg <= 1'b1;
                    state_reg     <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit for the RV32I core; sits directly downstream of the instruction decoder.
- Accepts one decoded LOAD/STORE (direction plus funct3 width code) at a time.
- Drives a word-wide req/gnt/rvalid data-memory port, generating byte enables and replicating store data.
- Returns sign- or zero-extended load data to writeback, and reports misaligned or illegal accesses without touching memory.

Parameters:
- XLEN, 32, data and address width; only 32 is supported.
- RD_W, 5, width of the destination register index.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  decoder presents an access.
- req_ready_o  out  1  stage can accept; high only in IDLE.
- req_we_i  in  1  1 = store (OPCODE_STORE), 0 = load (OPCODE_LOAD).
- req_funct3_i  in  3  width code: BYTE 000, HALF 001, WORD 010, BYTEU 100, HALFU 101.
- req_addr_i  in  XLEN  effective byte address (rs1 + imm).
- req_wdata_i  in  XLEN  rs2 value for stores.
- req_rd_i  in  RD_W  load destination register.
- mem_req_o  out  1  memory request.
- mem_gnt_i  in  1  memory accepts request this cycle.
- mem_addr_o  out  XLEN  word-aligned address, req_addr & ~3.
- mem_we_o  out  1  write enable.
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  XLEN  lane-replicated store data.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  XLEN  read word.
- wb_valid_o  out  1  one-cycle pulse: load result valid.
- wb_rd_o  out  RD_W  destination register.
- wb_data_o  out  XLEN  extended load data.
- st_done_o  out  1  one-cycle pulse: store committed.
- err_o  out  1  one-cycle pulse: misaligned or illegal access.
- err_addr_o  out  XLEN  faulting byte address.

Behaviour:
- **Reset.** All outputs are registered. On reset, all outputs are 0, state = IDLE, and any captured request or pending response is discarded. Reset may assert in any state; the next operation starts clean. A stray mem_rvalid_i after reset is ignored.
- **States:** IDLE, REQ, WAIT, RESP.
- **IDLE.**
  - req_ready_o = 1.
  - On req_valid_i, capture the request and check legality.
  - Illegal cases: HALF/HALFU with addr[0] = 1; WORD with addr[1:0] ≠ 0; funct3 ∈ {011, 110, 111}; store with funct3[2] = 1.
  - If illegal: go to RESP with err_o pending; no memory request is issued.
  - Otherwise: go to REQ.
- **REQ.**
  - mem_req_o = 1; mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o stay stable until mem_gnt_i.
  - On gnt, a store goes to RESP and a load goes to WAIT.
  - mem_rvalid_i in REQ is a protocol violation and is ignored.
- **WAIT.**
  - mem_req_o = 0.
  - On mem_rvalid_i, extract and extend the data, register it, then go to RESP.
- **RESP.**
  - Exactly one of wb_valid_o, st_done_o or err_o is high for one cycle.
  - req_ready_o = 0.
  - Next state is IDLE.
- **Byte enables:** BYTE = 4'b0001 << addr[1:0]; HALF = 4'b0011 << addr[1:0]; WORD = 4'b1111.
- **Store data:** byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word passes through.
- **Load data:**
  - shifted = rdata >> (8·addr[1:0]).
  - BYTE sign-extends shifted[7:0]; BYTEU zero-extends it.
  - HALF sign-extends shifted[15:0]; HALFU zero-extends it.
  - WORD passes rdata through.
- **Latency.** Accept at edge T. mem_req_o is high from T+1.
  - Store with gnt at T+1: st_done_o at T+2, ready again at T+3.
  - Load with gnt at T+1 and rvalid at T+2: wb_valid_o at T+3.
  - Error: err_o at T+1.
- **Output stability.** wb_data_o, wb_rd_o and err_addr_o hold their last value outside pulses.
- **Scope.** No back-to-back overlap; at most one outstanding transaction.

Test Plan:
- LB addr 0x1003, rdata 0x80FF1234, gnt and rvalid immediate → be 4'b1000, mem_addr 0x1000, wb_data 0xFFFFFF80, wb_valid pulse at T+3.
- LHU addr 0x2002, rdata 0xBEEF0000, rd = 7 → be 4'b1100, wb_data 0x0000BEEF, wb_rd 7.
- SB addr 0x0103, wdata 0x123456AA, gnt delayed 3 cycles → mem_wdata 0xAAAAAAAA, be 4'b1000, all mem outputs stable across the 3 stall cycles, st_done exactly one cycle after gnt.
- LW addr 0x0102 → err_o pulse at T+1, err_addr 0x102, mem_req_o never asserted; same result for SH addr 0x0001 and for store with funct3 100.
- Load accepted, gnt given, rst_ni dropped in WAIT, then rvalid → all outputs 0, no wb_valid; the next LW addr 0x10 with rdata 0xDEADBEEF returns 0xDEADBEEF.
- mem_rvalid_i pulsed in IDLE and in REQ before gnt → ignored; req_ready_o low from accept until return to IDLE.
